// File: rtl/sort_pkg.sv
// Shared definitions for the sorter front end: sort direction, pipeline
// latency of the bitonic sorter and the pad value used to fill short frames.
package sort_pkg;

   typedef enum logic {
      DIR_ASCENDING  = 1'b0,
      DIR_DESCENDING = 1'b1
   } sort_dir_e;

   // Number of compare/exchange stages in a bitonic network of 2**depth inputs.
   function automatic int sort_latency(input int depth);
      return depth * (depth + 1) / 2;
   endfunction

   // Pads must sort behind every real value: the largest value when sorting
   // ascending, the smallest when sorting descending. A shift by 64 wraps to
   // zero, so the subtraction still yields all ones for 64-bit values.
   function automatic logic [63:0] pad_value(input sort_dir_e direction, input int value_bits);
      if (direction == DIR_DESCENDING) begin
         return '0;
      end
      return (64'd1 << value_bits) - 64'd1;
   endfunction

endpackage

// File: rtl/sort_frame_packer_if.sv
// Bundle between the value stream, the frame bus to the sorter and the
// sideband strobe that marks sorted frames on the sorter output.
//
// Handshake: a value transfers on every rising edge where s_valid and s_ready
// are both high. s_data/s_last are only meaningful while s_valid is high and
// must stay stable until the transfer. s_ready does not depend on s_valid.
interface sort_frame_packer_if #(
   parameter int VALUE_BITS = 8,
   parameter int DEPTH      = 1
);
   localparam int SIZE = 1 << DEPTH;

   logic                             s_valid;
   logic                             s_ready;
   logic [VALUE_BITS-1:0]            s_data;
   logic                             s_last;
   logic [SIZE-1:0][VALUE_BITS-1:0]  frame;
   logic                             out_valid;
   logic [DEPTH:0]                   out_count;
   logic                             out_last;

   // Upstream producer / observer of the sideband.
   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, frame, out_valid, out_count, out_last
   );

   // The packer itself.
   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, frame, out_valid, out_count, out_last
   );
endinterface

// File: rtl/latency_pipe.sv
// Reset-clearable shift register of STAGES words; output is the last stage.
module latency_pipe #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   // Shift one stage per cycle; reset empties every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/sort_frame_packer.sv
// Packs a one-value-per-cycle stream into SIZE-wide frames for the bitonic
// sorter and emits a strobe aligned with the sorted result of each frame.
module sort_frame_packer
   import sort_pkg::*;
#(
   parameter int VALUE_BITS   = 8,
   parameter int DEPTH        = 1,
   parameter int DIRECTION    = 0,
   parameter int SIZE         = 1 << DEPTH,
   parameter int SORT_LATENCY = sort_latency(DEPTH)
) (
   input logic                clk,
   input logic                rst,
   sort_frame_packer_if.slave bus
);
   localparam int                    CNT_BITS  = DEPTH + 1;
   localparam sort_dir_e             DIR       = sort_dir_e'(DIRECTION[0]);
   localparam logic [VALUE_BITS-1:0] PAD       = VALUE_BITS'(pad_value(DIR, VALUE_BITS));
   localparam logic [DEPTH-1:0]      LAST_SLOT = DEPTH'(SIZE - 1);

   typedef struct packed {
      logic                valid;
      logic [CNT_BITS-1:0] count;
      logic                last;
   } token_t;

   logic                            r_ready;
   logic [DEPTH-1:0]                r_cnt;
   logic [SIZE-1:0][VALUE_BITS-1:0] r_buf;
   logic [SIZE-1:0][VALUE_BITS-1:0] r_frame;
   logic [SIZE-1:0][VALUE_BITS-1:0] w_frame_next;
   logic                            w_accept;
   logic                            w_close;
   token_t                          w_tok_in;
   token_t                          w_tok_out;

   assign w_accept = bus.s_valid && r_ready;
   assign w_close  = w_accept && (bus.s_last || (r_cnt == LAST_SLOT));

   // Ready is a registered copy of !rst: low in reset and the cycle after.
   always_ff @(posedge clk) begin
      r_ready <= !rst;
   end

   // Fill counter: advances per accepted value, wraps to 0 on every close.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_close) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + DEPTH'(1);
      end
   end

   // Fill buffer holds data only; a stale slot is never read past r_cnt.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_cnt] <= bus.s_data;
      end
   end

   // Closing frame: buffered values below r_cnt, the incoming value at r_cnt, pads above.
   always_comb begin
      w_frame_next = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (DEPTH'(i) < r_cnt) begin
            w_frame_next[i] = r_buf[i];
         end else if (DEPTH'(i) == r_cnt) begin
            w_frame_next[i] = bus.s_data;
         end else begin
            w_frame_next[i] = PAD;
         end
      end
   end

   // Frame register holds its contents between closes so filling can overlap sorting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
      end else if (w_close) begin
         r_frame <= w_frame_next;
      end
   end

   // Token for the closing frame; an all-zero bubble when nothing closes.
   always_comb begin
      w_tok_in = '0;
      if (w_close) begin
         w_tok_in.valid = 1'b1;
         w_tok_in.count = {1'b0, r_cnt} + CNT_BITS'(1);
         w_tok_in.last  = bus.s_last;
      end
   end

   // One extra stage covers the edge at which the sorter captures the frame.
   latency_pipe #(
      .WIDTH  ($bits(token_t)),
      .STAGES (SORT_LATENCY + 1)
   ) u_pipe (
      .clk (clk),
      .rst (rst),
      .i_d (w_tok_in),
      .o_q (w_tok_out)
   );

   assign bus.s_ready   = r_ready;
   assign bus.frame     = r_frame;
   assign bus.out_valid = w_tok_out.valid;
   assign bus.out_count = w_tok_out.count;
   assign bus.out_last  = w_tok_out.last;
endmodule

// File: tb/tb_sort_frame_packer.sv
// Bench for sort_frame_packer: two instances (DEPTH=2 ascending, DEPTH=3
// descending), a behavioural sorter per instance and an expected-frame
// scoreboard popped on every out_valid.
module tb_sort_frame_packer;
   localparam int EW    = 101;  // {cycle[31:0], count[3:0], last, sorted[63:0]}
   localparam int LAT_A = 3;
   localparam int LAT_B = 6;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;

   logic [EW-1:0] exp_qa[$];
   logic [EW-1:0] exp_qb[$];
   logic [7:0]    m_buf[2][8];
   int            m_cnt[2];

   logic [63:0] srt_a[LAT_A];
   logic [63:0] srt_b[LAT_B];

   sort_frame_packer_if #(.VALUE_BITS(8), .DEPTH(2)) if_a ();
   sort_frame_packer_if #(.VALUE_BITS(8), .DEPTH(3)) if_b ();

   sort_frame_packer #(.VALUE_BITS(8), .DEPTH(2), .DIRECTION(0)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   sort_frame_packer #(.VALUE_BITS(8), .DEPTH(3), .DIRECTION(1)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   // ---------------- clock / reset / cycle count ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before the end of the test sequence");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] sort_bytes(input logic [63:0] v, input int sz, input bit desc);
      logic [7:0]  a[8];
      logic [7:0]  t;
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
      for (int i = 0; i < sz; i++) begin
         for (int j = 0; j < sz - 1 - i; j++) begin
            if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      for (int i = 0; i < sz; i++) r[i*8 +: 8] = a[i];
      return r;
   endfunction

   // ---------------- behavioural sorters ----------------
   // Each captures its frame every edge and presents it sorted LAT edges later.
   always @(posedge clk) begin
      srt_a[0] <= 64'(if_a.frame);
      for (int k = 1; k < LAT_A; k++) srt_a[k] <= srt_a[k-1];
      srt_b[0] <= 64'(if_b.frame);
      for (int k = 1; k < LAT_B; k++) srt_b[k] <= srt_b[k-1];
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst) begin
         if (if_a.out_valid) begin
            if (exp_qa.size() == 0) begin
               check_eq("a_unexpected_out_valid", 128'(if_a.out_valid), '0);
            end else begin
               e = exp_qa.pop_front();
               check_eq("a_out_cycle", 128'(cyc), 128'(e[100:69]));
               check_eq("a_out_count", 128'(if_a.out_count), 128'(e[68:65]));
               check_eq("a_out_last", 128'(if_a.out_last), 128'(e[64]));
               check_eq("a_sorted", 128'(sort_bytes(srt_a[LAT_A-1], 4, 1'b0)), 128'(e[63:0]));
            end
         end else begin
            check_eq("a_idle_sideband", 128'({if_a.out_count, if_a.out_last}), '0);
         end
         if (if_b.out_valid) begin
            if (exp_qb.size() == 0) begin
               check_eq("b_unexpected_out_valid", 128'(if_b.out_valid), '0);
            end else begin
               e = exp_qb.pop_front();
               check_eq("b_out_cycle", 128'(cyc), 128'(e[100:69]));
               check_eq("b_out_count", 128'(if_b.out_count), 128'(e[68:65]));
               check_eq("b_out_last", 128'(if_b.out_last), 128'(e[64]));
               check_eq("b_sorted", 128'(sort_bytes(srt_b[LAT_B-1], 8, 1'b1)), 128'(e[63:0]));
            end
         end else begin
            check_eq("b_idle_sideband", 128'({if_b.out_count, if_b.out_last}), '0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic ready_of(input int inst);
      return (inst == 0) ? if_a.s_ready : if_b.s_ready;
   endfunction

   function automatic logic [63:0] frame_of(input int inst);
      return (inst == 0) ? 64'(if_a.frame) : 64'(if_b.frame);
   endfunction

   task automatic set_inputs(input int inst, input logic v, input logic [7:0] d, input logic l);
      if (inst == 0) begin
         if_a.s_valid = v; if_a.s_data = d; if_a.s_last = l;
      end else begin
         if_b.s_valid = v; if_b.s_data = d; if_b.s_last = l;
      end
   endtask

   // Offer one value; predict the frame and its sorted result when it closes.
   task automatic drive(input int inst, input logic [7:0] d, input logic l);
      int          n;
      bit          cl;
      int          sz;
      int          lat;
      logic [7:0]  pad;
      logic [63:0] ef;
      n   = 0;
      sz  = (inst == 0) ? 4 : 8;
      lat = (inst == 0) ? LAT_A : LAT_B;
      pad = (inst == 0) ? 8'hFF : 8'h00;
      ef  = '0;
      @(negedge clk);
      while (!ready_of(inst) && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!ready_of(inst)) check_eq("ready_timeout", 128'(ready_of(inst)), 128'(1));
      set_inputs(inst, 1'b1, d, l);
      m_buf[inst][m_cnt[inst]] = d;
      cl = l || (m_cnt[inst] == sz - 1);
      if (cl) begin
         for (int i = 0; i < sz; i++) ef[i*8 +: 8] = (i <= m_cnt[inst]) ? m_buf[inst][i] : pad;
         if (inst == 0) exp_qa.push_back({32'(cyc + 1 + lat), 4'(m_cnt[inst] + 1), l, sort_bytes(ef, sz, 1'b0)});
         else           exp_qb.push_back({32'(cyc + 1 + lat), 4'(m_cnt[inst] + 1), l, sort_bytes(ef, sz, 1'b1)});
         m_cnt[inst] = 0;
      end else begin
         m_cnt[inst]++;
      end
      @(posedge clk);
      #1;
      set_inputs(inst, 1'b0, 8'h00, 1'b0);
      if (cl) check_eq((inst == 0) ? "a_frame" : "b_frame", 128'(frame_of(inst)), 128'(ef));
   endtask

   // Hold reset for the given cycles, checking the cleared state each cycle.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            exp_qa.delete();
            exp_qb.delete();
            m_cnt[0] = 0;
            m_cnt[1] = 0;
         end
         check_eq("rst_ready", 128'({if_a.s_ready, if_b.s_ready}), '0);
         check_eq("rst_out_valid", 128'({if_a.out_valid, if_b.out_valid}), '0);
         check_eq("rst_sideband", 128'({if_a.out_count, if_a.out_last, if_b.out_count, if_b.out_last}), '0);
         check_eq("rst_frame", 128'({frame_of(0), frame_of(1)}), '0);
      end
      @(negedge clk);
      rst = 1'b0;
      check_eq("ready_first_cycle_after_reset", 128'({if_a.s_ready, if_b.s_ready}), '0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_empty", 128'(exp_qa.size() + exp_qb.size()), '0);
      repeat (2) @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst   = 1'b1;
      cyc   = 0;
      n_cmp = 0;
      n_err = 0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      set_inputs(0, 1'b0, 8'h00, 1'b0);
      set_inputs(1, 1'b0, 8'h00, 1'b0);
      do_reset(3);

      // Full frame, no s_last: 7,3,9,1 -> sorted 1,3,7,9, count 4, last 0.
      drive(0, 8'd7, 1'b0);
      drive(0, 8'd3, 1'b0);
      drive(0, 8'd9, 1'b0);
      drive(0, 8'd1, 1'b0);
      check_eq("a_frame_directed", 128'(frame_of(0)), 128'(32'h01_09_03_07));
      drain();

      // Partial frame 5,2 closed by s_last: pads FF above.
      drive(0, 8'd5, 1'b0);
      drive(0, 8'd2, 1'b1);
      check_eq("a_frame_partial", 128'(frame_of(0)), 128'(32'hFF_FF_02_05));
      drain();

      // Descending instance, 4,8,6 closed by s_last: pads 00.
      drive(1, 8'd4, 1'b0);
      drive(1, 8'd8, 1'b0);
      drive(1, 8'd6, 1'b1);
      drain();

      // 64 back-to-back random values on the DEPTH=3 instance: 8 frames.
      for (int i = 0; i < 64; i++) drive(1, 8'($urandom_range(0, 255)), 1'b0);
      drain();

      // s_last on every value: three one-value frames on consecutive cycles.
      drive(0, 8'd1, 1'b1);
      drive(0, 8'd2, 1'b1);
      drive(0, 8'd3, 1'b1);
      drain();

      // Random values, random s_last, random idle gaps.
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         drive(0, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      end
      drive(0, 8'hFF, 1'b1);
      drain();

      // Reset mid-fill after two accepts: partial frame discarded.
      drive(0, 8'd40, 1'b0);
      drive(0, 8'd30, 1'b0);
      do_reset(2);
      drive(0, 8'd13, 1'b0);
      drive(0, 8'd11, 1'b0);
      drive(0, 8'd14, 1'b0);
      drive(0, 8'd12, 1'b0);
      drain();

      // Reset one cycle after a close: that frame never raises out_valid.
      drive(0, 8'd21, 1'b0);
      drive(0, 8'd20, 1'b1);
      do_reset(2);
      drive(0, 8'd6, 1'b0);
      drive(0, 8'd8, 1'b0);
      drive(0, 8'd5, 1'b0);
      drive(0, 8'd7, 1'b0);
      drain();

      repeat (10) @(negedge clk);
      check_eq("a_queue_empty_end", 128'(exp_qa.size()), '0);
      check_eq("b_queue_empty_end", 128'(exp_qb.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sort_frame_packer.md
# sort_frame_packer

- Upstream stage of the bitonic `sorter`: packs a one-value-per-cycle stream into SIZE-wide frames and drives the sorter's `in` port.
- Fills a partial frame (closed by `s_last`) with pad values so that the real values sort to the low indices.
- Produces a sideband strobe delayed to line up with the cycle in which the sorter's `out` holds that frame sorted, carrying the frame's real-value count and last flag.

## Interface
- `VALUE_BITS`, 8, width of one value.
- `DEPTH`, 1, log2 of frame size; must match the sorter.
- `DIRECTION`, 0, sorter direction: 0 = ascending by index, 1 = descending.
- `SIZE`, `1 << DEPTH`, frame size; derived, do not override.
- `SORT_LATENCY`, `DEPTH*(DEPTH+1)/2`, sorter pipeline depth in cycles; derived, do not override.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input value valid.
- `s_ready` out 1: input accept.
- `s_data` in VALUE_BITS: input value.
- `s_last` in 1: closes the current frame with this value.
- `frame` out `[SIZE-1:0][VALUE_BITS-1:0]`: connects to sorter `in`.
- `out_valid` out 1: sorter `out` holds a sorted frame this cycle.
- `out_count` out DEPTH+1: number of real values in that frame, 1..SIZE.
- `out_last` out 1: that frame was closed by `s_last`.

## Operation
- **Handshake and reset outputs**
  - A value is accepted on any edge with `s_valid && s_ready`.
  - `s_ready` = !`rst`, registered: 0 during reset and the first cycle after, 1 otherwise. The block never back-pressures.
- **Fill buffer**
  - Fill buffer `buf[SIZE]` plus fill counter `cnt`, 0..SIZE-1.
  - An accepted value is written to `buf[cnt]` and `cnt` increments.
- **Frame close**
  - A frame closes when an accepted value has `s_last=1` or `cnt==SIZE-1`.
  - On close, in the same edge:
    - `frame[i]` is loaded with `buf[i]` for i<`cnt`, with the incoming value at `cnt`, and with PAD for i>`cnt`.
    - `cnt` returns to 0.
    - A token {count=`cnt`+1, last=`s_last`} enters the latency pipe.
  - PAD is all-ones when DIRECTION=0 and all-zeros when DIRECTION=1, so pads always sort to indices ≥ count.
- **Independence of fill and frame**
  - Fill and `frame` are independent, so the next frame can begin filling on the cycle after a close.
  - Back-to-back closes are allowed: with `s_last` every cycle, each cycle carries a one-value frame.
  - `frame` holds its last value between closes. The sorter still samples it every cycle, but no token is generated, so those results are ignored.
- **Latency pipe**
  - SORT_LATENCY+1 stages of {valid, count, last}.
  - It shifts every cycle, and a bubble (valid=0) enters when no frame closes.
  - `out_valid`, `out_count` and `out_last` are the final stage.
  - `out_count` and `out_last` are meaningful only while `out_valid`=1 and hold 0 otherwise.
- **Reset** (any cycle, including mid-fill)
  - `cnt`=0; the partial frame is discarded.
  - `frame`=all zero.
  - All pipe stages: valid=0, count=0, last=0. Therefore `out_valid`=0, `out_count`=0, `out_last`=0.
  - Frames already inside the sorter at reset are lost: their tokens are cleared, so no `out_valid` is ever asserted for them.
- **Restrictions**
  - `s_last` with `s_valid=0` is ignored.
  - An empty frame is impossible: `s_last` always accompanies a value.

## Timing
- Close on edge t → `frame` valid after t.
- The sorter's first stage captures `frame` at edge t+1, and its result is on `out` after edge t+SORT_LATENCY.
- `out_valid` is high for exactly the one cycle following edge t+SORT_LATENCY. A token enters at edge t and reaches the final stage after SORT_LATENCY further edges.
- Throughput is one value per cycle sustained.
- Closed-frame rate: at most one frame per cycle.
- DEPTH=1 → SORT_LATENCY=1; DEPTH=10 → SORT_LATENCY=55.

## Structure
- Package `sort_pkg`:
  - function `sort_latency(depth)`.
  - function `pad_value(direction, value_bits)`.
  - typedef for the sideband token {valid, count, last}, parameterised via localparams in the user module.
- Sub-module `latency_pipe`: generic reset-clearable shift register (params WIDTH, STAGES), used for the token path.
- Bench top instantiates `sort_frame_packer` + `sorter` with matching DEPTH/DIRECTION/VALUE_BITS and checks `sorter.out` whenever `out_valid`=1.

## Test plan
- DEPTH=2, DIRECTION=0, stream 7,3,9,1, no `s_last`:
  - `frame`={1,9,3,7} (index 3..0) after the 4th accept.
  - `out_valid` exactly 1 cycle, SORT_LATENCY=3 edges later.
  - Sorted out[0..3]=1,3,7,9, `out_count`=4, `out_last`=0.
- DEPTH=2, DIRECTION=0, stream 5,2 with `s_last` on 2:
  - `frame`[3:2]=FF,FF.
  - Sorted out=2,5,FF,FF, `out_count`=2, `out_last`=1.
- DEPTH=2, DIRECTION=1, stream 4,8,6 with `s_last` on 6:
  - Pads 00; sorted out[0..3]=8,6,4,0.
  - `out_count`=3, `out_last`=1.
- DEPTH=3, 64 consecutive random values, `s_valid` held high:
  - 8 `out_valid` pulses on consecutive multiples of 8 cycles.
  - Each frame matches a sorted reference model, with no lost or duplicated frames.
- DEPTH=2, `s_last` on every value 1,2,3:
  - `out_valid` on 3 consecutive cycles, `out_count`=1 each.
  - out[0]=1,2,3 respectively, with pads FF above.
- DEPTH=2, reset asserted after 2 accepts, and again one cycle after a close:
  - `s_ready`=0 during reset.
  - No `out_valid` ever appears for either frame.
  - The next 4 values form a clean frame with `out_count`=4.
